// File: rtl/mips_lite_pkg.sv
// Shared MIPS-lite definitions: op classes, 6-bit opcodes, loader FSM states
// and the signed-16 immediate range helper.
package mips_lite_pkg;

  typedef enum logic [2:0] {
    CLS_RTYPE = 3'd0,
    CLS_LW    = 3'd1,
    CLS_SW    = 3'd2,
    CLS_BEQ   = 3'd3,
    CLS_BGTZ  = 3'd4,
    CLS_NORI  = 3'd5,
    CLS_JAL   = 3'd6,
    CLS_JSP   = 3'd7
  } op_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BGTZ  = 6'b100110;
  localparam logic [5:0] OP_NORI  = 6'b001101;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_JSP   = 6'b010010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_FULL = 2'd2
  } state_e;

  // A 26-bit immediate fits a signed 16-bit field when bits [25:15] are a pure sign extension.
  function automatic logic fits_simm16(input logic [25:0] imm);
    return (imm[25:15] == 11'h000) || (imm[25:15] == 11'h7FF);
  endfunction

endpackage

// File: rtl/instr_encode.sv
// Combinational MIPS-lite encoder: op class plus fields -> 32-bit word and a
// reject flag for immediates that do not fit the target format.
module instr_encode
  import mips_lite_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [4:0]  rs_i,
  input  logic [4:0]  rt_i,
  input  logic [4:0]  rd_i,
  input  logic [5:0]  funct_i,
  input  logic [25:0] imm_i,
  output logic [31:0] word_o,
  output logic        reject_o
);

  always_comb begin
    word_o   = 32'h0;
    reject_o = 1'b0;
    case (op_class_e'(op_i))
      CLS_RTYPE: word_o = {OP_RTYPE, rs_i, rt_i, rd_i, 5'b0, funct_i};
      CLS_LW: begin
        word_o   = {OP_LW, rs_i, rt_i, imm_i[15:0]};
        reject_o = !fits_simm16(imm_i);
      end
      CLS_SW: begin
        word_o   = {OP_SW, rs_i, rt_i, imm_i[15:0]};
        reject_o = !fits_simm16(imm_i);
      end
      CLS_BEQ: begin
        word_o   = {OP_BEQ, rs_i, rt_i, imm_i[15:0]};
        reject_o = !fits_simm16(imm_i);
      end
      CLS_BGTZ: begin
        word_o   = {OP_BGTZ, rs_i, rt_i, imm_i[15:0]};
        reject_o = !fits_simm16(imm_i);
      end
      // NORI zero-extends, so only the unsigned 16-bit range is legal.
      CLS_NORI: begin
        word_o   = {OP_NORI, rs_i, rt_i, imm_i[15:0]};
        reject_o = (imm_i[25:16] != 10'h0);
      end
      CLS_JAL:  word_o = {OP_JAL, imm_i};
      CLS_JSP:  word_o = {OP_JSP, rs_i, 21'b0};
      default:  word_o = 32'h0;
    endcase
  end

endmodule

// File: rtl/instr_loader.sv
// Sequential instruction-memory loader: encodes handshaked instructions and writes
// them to consecutive word addresses. Optional LOADER_CHECKSUM_EN adds a running XOR.
module instr_loader
  import mips_lite_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [4:0]        in_rs,
  input  logic [4:0]        in_rt,
  input  logic [4:0]        in_rd,
  input  logic [5:0]        in_funct,
  input  logic [25:0]       in_imm,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [ADDR_W:0]   word_count,
  output logic              err,
  output logic [7:0]        err_count,
  output logic              full
`ifdef LOADER_CHECKSUM_EN
  ,
  output logic [31:0]       checksum
`endif
);

  localparam logic [ADDR_W:0] LAST_CNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] CNT_ONE  = (ADDR_W + 1)'(1);

  state_e            state_q;
  logic [ADDR_W:0]   cnt_q;
  logic [ADDR_W:0]   cnt_d;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [31:0]       wr_data_q;
  logic              err_q;
  logic [7:0]        err_count_q;
  logic [31:0]       encWord;
  logic              encReject;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum_q;
`endif

  instr_encode u_encode (
    .op_i     (in_op),
    .rs_i     (in_rs),
    .rt_i     (in_rt),
    .rd_i     (in_rd),
    .funct_i  (in_funct),
    .imm_i    (in_imm),
    .word_o   (encWord),
    .reject_o (encReject)
  );

  assign cnt_d = cnt_q + CNT_ONE;

  // clear shares the reset path so it also cancels any accept in the same cycle.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= 32'h0;
      err_q       <= 1'b0;
      err_count_q <= 8'h0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q  <= 32'h0;
`endif
    end else begin
      wr_en_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      if (wr_en_q) checksum_q <= checksum_q ^ wr_data_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_LOAD;
            cnt_q   <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum_q <= 32'h0;
`endif
          end
        end
        ST_LOAD: begin
          if (in_valid) begin
            if (encReject) begin
              err_q <= 1'b1;
              if (err_count_q != 8'hFF) err_count_q <= err_count_q + 8'h1;
            end else begin
              wr_en_q   <= 1'b1;
              wr_addr_q <= cnt_q[ADDR_W-1:0];
              wr_data_q <= encWord;
              cnt_q     <= cnt_d;
              if (cnt_d == LAST_CNT) state_q <= ST_FULL;
            end
          end
        end
        ST_FULL: state_q <= ST_FULL;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign in_ready   = (state_q == ST_LOAD);
  assign full       = (state_q == ST_FULL);
  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign word_count = cnt_q;
  assign err        = err_q;
  assign err_count  = err_count_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_instr_loader.sv
// Directed bench for instr_loader (DEPTH=4, ADDR_W=2): vector table plus
// hand-written sequences for full, clear, reset, saturation and checksum.
module tb_instr_loader;

  localparam int ADDR_W = 2;
  localparam int DEPTH  = 4;

  logic              clk = 1'b0;
  logic              reset, start, clear, inValid;
  logic              inReady;
  logic [2:0]        inOp;
  logic [4:0]        inRs, inRt, inRd;
  logic [5:0]        inFunct;
  logic [25:0]       inImm;
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [31:0]       wrData;
  logic [ADDR_W:0]   wordCount;
  logic              err;
  logic [7:0]        errCount;
  logic              full;
`ifdef LOADER_CHECKSUM_EN
  logic [31:0]       checksum;
`endif

  int totalChecks = 0;
  int passChecks  = 0;
  int expCount    = 0;
  int expErr      = 0;

  typedef struct {
    logic [2:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [5:0]  funct;
    logic [25:0] imm;
    logic        reject;
    logic [31:0] word;
  } vec_t;

  vec_t vecs[10];

  instr_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .clear      (clear),
    .in_valid   (inValid),
    .in_ready   (inReady),
    .in_op      (inOp),
    .in_rs      (inRs),
    .in_rt      (inRt),
    .in_rd      (inRd),
    .in_funct   (inFunct),
    .in_imm     (inImm),
    .wr_en      (wrEn),
    .wr_addr    (wrAddr),
    .wr_data    (wrData),
    .word_count (wordCount),
    .err        (err),
    .err_count  (errCount),
    .full       (full)
`ifdef LOADER_CHECKSUM_EN
    ,
    .checksum   (checksum)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passChecks++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic setFields(input vec_t v);
    inOp = v.op; inRs = v.rs; inRt = v.rt; inRd = v.rd; inFunct = v.funct; inImm = v.imm;
  endtask

  task automatic restartLoad();
    clear = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    expCount = 0;
    expErr   = 0;
  endtask

  // One accept cycle, checked one cycle later against the table entry.
  task automatic applyStimulus(input int idx);
    vec_t v;
    v = vecs[idx];
    setFields(v);
    inValid = 1'b1;
    step();
    inValid = 1'b0;
    checkOutput($sformatf("v%0d wr_en", idx), 32'(wrEn), 32'(!v.reject));
    checkOutput($sformatf("v%0d err", idx), 32'(err), 32'(v.reject));
    if (v.reject) begin
      expErr++;
    end else begin
      checkOutput($sformatf("v%0d wr_addr", idx), 32'(wrAddr), 32'(expCount));
      checkOutput($sformatf("v%0d wr_data", idx), wrData, v.word);
      expCount++;
    end
    checkOutput($sformatf("v%0d word_count", idx), 32'(wordCount), 32'(expCount));
    checkOutput($sformatf("v%0d err_count", idx), 32'(errCount), 32'(expErr));
    if (expCount == DEPTH) begin
      checkOutput($sformatf("v%0d full", idx), 32'(full), 32'd1);
      checkOutput($sformatf("v%0d in_ready", idx), 32'(inReady), 32'd0);
      restartLoad();
    end
  endtask

  initial begin
    vecs[0] = '{3'd0, 5'd1,  5'd2, 5'd3, 6'h20, 26'h0000000, 1'b0, 32'h00221820};
    vecs[1] = '{3'd1, 5'd29, 5'd8, 5'd0, 6'h00, 26'h3FFFFFC, 1'b0, 32'h8FA8FFFC};
    vecs[2] = '{3'd5, 5'd1,  5'd2, 5'd0, 6'h00, 26'h0010000, 1'b1, 32'h0};
    vecs[3] = '{3'd6, 5'd0,  5'd0, 5'd0, 6'h00, 26'h0100000, 1'b0, 32'h0C100000};
    vecs[4] = '{3'd7, 5'd31, 5'd0, 5'd0, 6'h00, 26'h0000000, 1'b0, 32'h4BE00000};
    vecs[5] = '{3'd4, 5'd4,  5'd0, 5'd0, 6'h00, 26'h0000003, 1'b0, 32'h98800003};
    vecs[6] = '{3'd2, 5'd2,  5'd5, 5'd0, 6'h00, 26'h0008000, 1'b1, 32'h0};
    vecs[7] = '{3'd3, 5'd1,  5'd2, 5'd0, 6'h00, 26'h3FF8000, 1'b0, 32'h10228000};
    vecs[8] = '{3'd5, 5'd3,  5'd4, 5'd0, 6'h00, 26'h000FFFF, 1'b0, 32'h3464FFFF};
    vecs[9] = '{3'd1, 5'd1,  5'd1, 5'd0, 6'h00, 26'h0010000, 1'b1, 32'h0};

    reset = 1'b1; start = 1'b0; clear = 1'b0; inValid = 1'b0;
    setFields(vecs[0]);
    step();
    step();
    checkOutput("rst in_ready", 32'(inReady), 32'd0);
    checkOutput("rst wr_en", 32'(wrEn), 32'd0);
    checkOutput("rst wr_addr", 32'(wrAddr), 32'd0);
    checkOutput("rst wr_data", wrData, 32'd0);
    checkOutput("rst word_count", 32'(wordCount), 32'd0);
    checkOutput("rst err", 32'(err), 32'd0);
    checkOutput("rst err_count", 32'(errCount), 32'd0);
    checkOutput("rst full", 32'(full), 32'd0);
`ifdef LOADER_CHECKSUM_EN
    checkOutput("rst checksum", checksum, 32'd0);
`endif
    reset = 1'b0;
    step();

    // Valid without start is not accepted.
    inValid = 1'b1;
    step();
    inValid = 1'b0;
    checkOutput("idle no write", 32'(wrEn), 32'd0);

    restartLoad();
    checkOutput("start in_ready", 32'(inReady), 32'd1);
    for (int i = 0; i < 10; i++) applyStimulus(i);

    // Back-to-back stream of six words into a four-deep memory.
    restartLoad();
    setFields(vecs[0]);
    inValid = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      inFunct = 6'(i);
      step();
      if (i <= DEPTH) begin
        checkOutput($sformatf("burst%0d wr_en", i), 32'(wrEn), 32'd1);
        checkOutput($sformatf("burst%0d wr_addr", i), 32'(wrAddr), 32'(i - 1));
        checkOutput($sformatf("burst%0d wr_data", i), wrData, 32'h00221800 | 32'(i));
      end else begin
        checkOutput($sformatf("burst%0d held off", i), 32'(wrEn), 32'd0);
      end
      if (i == DEPTH) begin
        checkOutput("burst full", 32'(full), 32'd1);
        checkOutput("burst in_ready", 32'(inReady), 32'd0);
      end
    end
    inValid = 1'b0;
    checkOutput("burst word_count", 32'(wordCount), 32'd4);
    start = 1'b1;
    step();
    start = 1'b0;
    checkOutput("start in full ignored", 32'(full), 32'd1);
    checkOutput("start in full count", 32'(wordCount), 32'd4);

    // clear coinciding with an accepted word wins.
    restartLoad();
    applyStimulus(0);
    setFields(vecs[1]);
    inValid = 1'b1;
    clear = 1'b1;
    step();
    inValid = 1'b0;
    clear = 1'b0;
    checkOutput("clear wr_en", 32'(wrEn), 32'd0);
    checkOutput("clear in_ready", 32'(inReady), 32'd0);
    checkOutput("clear word_count", 32'(wordCount), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    setFields(vecs[2]);
    inValid = 1'b1;
    clear = 1'b1;
    step();
    inValid = 1'b0;
    clear = 1'b0;
    checkOutput("clear reject err", 32'(err), 32'd0);
    checkOutput("clear reject err_count", 32'(errCount), 32'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    expCount = 0;
    expErr = 0;
    applyStimulus(4);

    // Reset alongside an accept drops the write.
    setFields(vecs[0]);
    inValid = 1'b1;
    reset = 1'b1;
    step();
    inValid = 1'b0;
    reset = 1'b0;
    checkOutput("reset mid-load wr_en", 32'(wrEn), 32'd0);
    checkOutput("reset mid-load count", 32'(wordCount), 32'd0);
    checkOutput("reset mid-load in_ready", 32'(inReady), 32'd0);

    // err_count saturates at 255.
    restartLoad();
    setFields(vecs[2]);
    inValid = 1'b1;
    for (int i = 0; i < 260; i++) step();
    inValid = 1'b0;
    checkOutput("err_count saturate", 32'(errCount), 32'd255);
    checkOutput("rejects keep count", 32'(wordCount), 32'd0);
    checkOutput("reject still err", 32'(err), 32'd1);

`ifdef LOADER_CHECKSUM_EN
    restartLoad();
    setFields(vecs[0]);
    inValid = 1'b1;
    step();
    setFields(vecs[1]);
    step();
    inValid = 1'b0;
    checkOutput("checksum partial", checksum, 32'h00221820);
    step();
    checkOutput("checksum final", checksum, 32'h8F8AE7DC);
`endif

    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
